// File: rtl/ssd_pkg.sv
// Segment patterns and sizing limits shared by the scan controller and decoder.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package ssd_pkg;

    localparam int MAX_DIGITS = 8;

    // Active-low abcdefg patterns (bit 6 = a ... bit 0 = g); 0 lights a segment.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_lookup(input logic [3:0] nibble);
        logic [6:0] pat;
        case (nibble)
            4'h0: pat = SEG_0;
            4'h1: pat = SEG_1;
            4'h2: pat = SEG_2;
            4'h3: pat = SEG_3;
            4'h4: pat = SEG_4;
            4'h5: pat = SEG_5;
            4'h6: pat = SEG_6;
            4'h7: pat = SEG_7;
            4'h8: pat = SEG_8;
            4'h9: pat = SEG_9;
            4'hA: pat = SEG_A;
            4'hB: pat = SEG_B;
            4'hC: pat = SEG_C;
            4'hD: pat = SEG_D;
            4'hE: pat = SEG_E;
            default: pat = SEG_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Load-side and display-side signal bundle of the scan controller.
// Latency: none (wires only).
// Backpressure: none; a load is always accepted and pending reports an uncommitted load.
interface ssd_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   anode;
    logic [7:0]              cathode;
    logic                    pending;
    logic                    frame_tick;

    modport master (
        output load, value, dp_in, digit_en, blank_lz,
        input  anode, cathode, pending, frame_tick
    );

    modport slave (
        input  load, value, dp_in, digit_en, blank_lz,
        output anode, cathode, pending, frame_tick
    );
endinterface

// File: rtl/hex_to_ssd.sv
// Combinational hex nibble to abcdefg segment decoder with selectable polarity.
// Latency: 0 cycles (pure combinational).
// Backpressure: not applicable.
module hex_to_ssd
    import ssd_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    // Table is stored active-low; flip it for common-cathode style outputs.
    always_comb begin
        seg = (ACTIVE_LOW != 0) ? seg_lookup(nibble) : ~seg_lookup(nibble);
    end
endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-synchronous double-buffered loads.
// Latency: anode/cathode registered, 1 cycle after the index/prescaler state; loads commit at the next frame boundary.
// Backpressure: none; loads always accepted, last load before a boundary wins. Optional SSD_BRIGHTNESS_EN adds a duty-cycle input.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV_BITS = 18,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic clk,
    input  logic rst,
`ifdef SSD_BRIGHTNESS_EN
    input  logic [3:0] brightness,
`endif
    ssd_scan_ctrl_if.slave bus
);
    localparam logic       AL       = (ACTIVE_LOW != 0);
    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

    logic [SCAN_DIV_BITS-1:0] presc;
    logic [2:0]               idx;
    logic                     presc_wrap;
    logic                     frame_bnd;

    logic [4*NUM_DIGITS-1:0]  stg_value, disp_value;
    logic [NUM_DIGITS-1:0]    stg_dp, disp_dp;
    logic [NUM_DIGITS-1:0]    stg_en, disp_en;
    logic                     stg_blz, disp_blz;
    logic                     pending_q;
    logic                     frame_tick_q;

    logic [3:0]               nib_arr [MAX_DIGITS];
    logic [MAX_DIGITS-1:0]    dp_pad;
    logic [MAX_DIGITS-1:0]    en_pad;
    logic [MAX_DIGITS-1:0]    blank;

    logic [3:0]               sel_nib;
    logic                     sel_dp, sel_en, sel_blank;
    logic [6:0]               sel_seg;
    logic                     duty_ok;
    logic [NUM_DIGITS-1:0]    on_n;
    logic [7:0]               cath_n;

    logic [NUM_DIGITS-1:0]    anode_q;
    logic [7:0]               cathode_q;

    assign presc_wrap = &presc;
    assign frame_bnd  = presc_wrap && (idx == LAST_IDX);

    // Prescaler and digit index; the index steps once per full prescaler wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= 3'd0;
        end else begin
            presc <= presc + SCAN_DIV_BITS'(1);
            if (presc_wrap) begin
                idx <= frame_bnd ? 3'd0 : idx + 3'd1;
            end
        end
    end

    // Staging and display registers: display only changes on the frame boundary,
    // and a load landing on the boundary bypasses staging straight to display.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_value    <= '0;
            stg_dp       <= '0;
            stg_en       <= '0;
            stg_blz      <= 1'b0;
            disp_value   <= '0;
            disp_dp      <= '0;
            disp_en      <= '0;
            disp_blz     <= 1'b0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_bnd;
            if (frame_bnd) begin
                if (bus.load) begin
                    disp_value <= bus.value;
                    disp_dp    <= bus.dp_in;
                    disp_en    <= bus.digit_en;
                    disp_blz   <= bus.blank_lz;
                end else if (pending_q) begin
                    disp_value <= stg_value;
                    disp_dp    <= stg_dp;
                    disp_en    <= stg_en;
                    disp_blz   <= stg_blz;
                end
                pending_q <= 1'b0;
            end else if (bus.load) begin
                stg_value <= bus.value;
                stg_dp    <= bus.dp_in;
                stg_en    <= bus.digit_en;
                stg_blz   <= bus.blank_lz;
                pending_q <= 1'b1;
            end
        end
    end

    // Pad per-digit display fields to the maximum digit count so the 3-bit
    // index always selects inside the arrays.
    for (genvar g = 0; g < MAX_DIGITS; g++) begin : g_pad
        if (g < NUM_DIGITS) begin : g_real
            assign nib_arr[g] = disp_value[4*g +: 4];
            assign dp_pad[g]  = disp_dp[g];
            assign en_pad[g]  = disp_en[g];
        end else begin : g_fill
            assign nib_arr[g] = 4'h0;
            assign dp_pad[g]  = 1'b0;
            assign en_pad[g]  = 1'b0;
        end
    end

    // Leading-zero mask: walk down from the top digit while digits are zero with
    // no decimal point; the first visible digit ends the run. Digit 0 always shows.
    always_comb begin : blank_mask
        logic lead;
        blank = '0;
        lead  = disp_blz;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < NUM_DIGITS) begin
                if (lead && (nib_arr[i] == 4'h0) && !dp_pad[i]) begin
                    blank[i] = 1'b1;
                end else begin
                    lead = 1'b0;
                end
            end
        end
    end

    assign sel_nib   = nib_arr[idx];
    assign sel_dp    = dp_pad[idx];
    assign sel_en    = en_pad[idx];
    assign sel_blank = blank[idx];

    hex_to_ssd #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
        .nibble (sel_nib),
        .seg    (sel_seg)
    );

`ifdef SSD_BRIGHTNESS_EN
    assign duty_ok = (presc[SCAN_DIV_BITS-1 -: 4] <= brightness);
`else
    assign duty_ok = 1'b1;
`endif

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_onehot
        assign on_n[g] = sel_en && duty_ok && (idx == 3'(g));
    end

    // Segment pattern for the current slot; disabled or blanked digits go dark.
    always_comb begin
        cath_n = {8{AL}};
        if (sel_en && !sel_blank) begin
            cath_n = {sel_seg, sel_dp ^ AL};
        end
    end

    // Registered pin drivers, forced inactive in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            anode_q   <= {NUM_DIGITS{AL}};
            cathode_q <= {8{AL}};
        end else begin
            anode_q   <= on_n ^ {NUM_DIGITS{AL}};
            cathode_q <= cath_n;
        end
    end

    assign bus.anode      = anode_q;
    assign bus.cathode    = cathode_q;
    assign bus.pending    = pending_q;
    assign bus.frame_tick = frame_tick_q;
endmodule
